// File: rtl/lr35902_irqctl.sv
// LR35902 interrupt controller: IF/IE/IME registers, priority select and the
// request/acknowledge dispatch handshake that hands the CPU its vector.
module lr35902_irqctl (
    input  logic       clk,
    input  logic       reset,
    output logic [7:0] dout,
    input  logic [7:0] din,
    input  logic       adr,
    input  logic       read,
    input  logic       write,
    input  logic [4:0] irq_in,
    input  logic       ime_set,
    input  logic       ime_clr,
    output logic       int_req,
    output logic       wake,
    input  logic       int_ack,
    output logic [7:0] int_vec,
    output logic       int_vec_valid
);

    typedef enum logic [1:0] {StIdle, StSel, StHold} state_e;

    state_e     state_q, state_d;
    logic [4:0] if_q, if_d;
    logic [7:0] ie_q, ie_d;
    logic       ime_q, ime_d;
    logic       read_q, write_q, ack_q;
    logic [7:0] dout_q, dout_d;
    logic [7:0] vec_q, vec_d;
    logic       vld_q, vld_d;

    logic [4:0] pend;
    logic [4:0] sel_mask;
    logic [2:0] sel_idx;
    logic       rd_fire, wr_fire, ack_rise;

    always_comb begin
        pend     = if_q & ie_q[4:0];
        // Isolate the lowest set bit: bit0 has the highest priority.
        sel_mask = pend & (~pend + 5'd1);
        sel_idx  = 3'd0;
        for (int i = 4; i >= 0; i--) begin
            if (pend[i]) sel_idx = 3'(i);
        end
    end

    assign rd_fire  = read & ~read_q;
    assign wr_fire  = ~write & write_q;
    assign ack_rise = int_ack & ~ack_q;

    always_comb begin
        dout_d  = dout_q;
        if_d    = if_q;
        ie_d    = ie_q;
        ime_d   = ime_q;
        state_d = state_q;
        vec_d   = vec_q;
        vld_d   = vld_q;

        if (rd_fire) dout_d = adr ? ie_q : {3'b111, if_q};

        if (wr_fire) begin
            if (adr) ie_d = din;
            else     if_d = din[4:0];
        end

        if (ime_set) ime_d = 1'b1;
        if (ime_clr) ime_d = 1'b0;

        case (state_q)
            StIdle: begin
                if (ack_rise) state_d = StSel;
            end
            StSel: begin
                if_d    = if_d & ~sel_mask;
                ime_d   = 1'b0;
                vec_d   = (|pend) ? (8'h40 + {2'b00, sel_idx, 3'b000}) : 8'h00;
                vld_d   = 1'b1;
                state_d = StHold;
            end
            StHold: begin
                if (!int_ack) begin
                    vld_d   = 1'b0;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // Hardware requests are applied last so they win over write and clear.
        if_d = if_d | irq_in;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            if_q    <= 5'd0;
            ie_q    <= 8'd0;
            ime_q   <= 1'b0;
            read_q  <= 1'b0;
            write_q <= 1'b0;
            ack_q   <= 1'b0;
            dout_q  <= 8'd0;
            vec_q   <= 8'd0;
            vld_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if_q    <= if_d;
            ie_q    <= ie_d;
            ime_q   <= ime_d;
            read_q  <= read;
            write_q <= write;
            ack_q   <= int_ack;
            dout_q  <= dout_d;
            vec_q   <= vec_d;
            vld_q   <= vld_d;
        end
    end

    assign wake          = |pend;
    assign int_req       = ime_q & (|pend) & (state_q == StIdle);
    assign dout          = dout_q;
    assign int_vec       = vec_q;
    assign int_vec_valid = vld_q;

endmodule

// File: tb/tb_lr35902_irqctl.sv
// Scoreboard bench for lr35902_irqctl: transaction-level model predicts read
// data and dispatch vectors; monitors pop and compare as the DUT presents them.
module tb_lr35902_irqctl;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] dout;
    logic [7:0] din;
    logic       adr;
    logic       read;
    logic       write;
    logic [4:0] irq_in;
    logic       ime_set;
    logic       ime_clr;
    logic       int_req;
    logic       wake;
    logic       int_ack;
    logic [7:0] int_vec;
    logic       int_vec_valid;

    lr35902_irqctl dut (
        .clk          (clk),
        .reset        (reset),
        .dout         (dout),
        .din          (din),
        .adr          (adr),
        .read         (read),
        .write        (write),
        .irq_in       (irq_in),
        .ime_set      (ime_set),
        .ime_clr      (ime_clr),
        .int_req      (int_req),
        .wake         (wake),
        .int_ack      (int_ack),
        .int_vec      (int_vec),
        .int_vec_valid(int_vec_valid)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state
    logic [4:0] m_if;
    logic [7:0] m_ie;
    logic       m_ime;

    logic [7:0] exp_rd[$];
    logic [7:0] exp_vec[$];

    function automatic void check(string name, int act, int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endfunction

    function automatic logic [4:0] m_pend();
        return m_if & m_ie[4:0];
    endfunction

    // Dispatch as the CPU sees it: lowest pending source wins, its IF bit and
    // IME are cleared, and a request that vanished yields vector 00.
    function automatic logic [7:0] model_dispatch(logic [4:0] irq_during);
        logic [4:0] p;
        logic [7:0] v;
        bit         found;
        p     = m_pend();
        v     = 8'h00;
        found = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (p[i] && !found) begin
                found = 1'b1;
                v     = 8'h40 + 8'(8 * i);
                m_if[i] = 1'b0;
            end
        end
        m_ime = 1'b0;
        m_if  = m_if | irq_during;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset   = 1'b1;
        din     = 8'h00;
        adr     = 1'b0;
        read    = 1'b0;
        write   = 1'b0;
        irq_in  = 5'd0;
        ime_set = 1'b0;
        ime_clr = 1'b0;
        int_ack = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        m_if  = 5'd0;
        m_ie  = 8'd0;
        m_ime = 1'b0;
    endtask

    task automatic check_levels(string tag);
        check({tag, ".wake"}, int'(wake), int'(|m_pend()));
        check({tag, ".int_req"}, int'(int_req), int'(m_ime && (|m_pend())));
    endtask

    task automatic bus_write(logic a, logic [7:0] d, logic [4:0] irqm);
        adr   = a;
        din   = d;
        write = 1'b1;
        tick();
        write  = 1'b0;
        irq_in = irqm;
        tick();
        irq_in = 5'd0;
        if (a) m_ie = d;
        else   m_if = d[4:0];
        m_if = m_if | irqm;
    endtask

    task automatic bus_read(logic a);
        exp_rd.push_back(a ? m_ie : {3'b111, m_if});
        adr  = a;
        read = 1'b1;
        tick();
        read = 1'b0;
        tick();
    endtask

    task automatic pulse(logic [4:0] m);
        irq_in = m;
        tick();
        irq_in = 5'd0;
        m_if   = m_if | m;
    endtask

    task automatic ime_op(logic s, logic c);
        ime_set = s;
        ime_clr = c;
        tick();
        ime_set = 1'b0;
        ime_clr = 1'b0;
        if (s) m_ime = 1'b1;
        if (c) m_ime = 1'b0;
    endtask

    // Ack rising edge, optional irq pulse during SEL, then release in HOLD.
    task automatic dispatch(string tag, logic [4:0] irq_during);
        exp_vec.push_back(model_dispatch(irq_during));
        int_ack = 1'b1;
        tick();
        check({tag, ".sel_req_low"}, int'(int_req), 0);
        check({tag, ".sel_vld_low"}, int'(int_vec_valid), 0);
        irq_in = irq_during;
        tick();
        irq_in = 5'd0;
        check({tag, ".vld_at_n2"}, int'(int_vec_valid), 1);
        int_ack = 1'b0;
        tick();
        check({tag, ".vld_dropped"}, int'(int_vec_valid), 0);
    endtask

    // Read-data monitor: tracks the read strobe edge like the bus does.
    initial begin
        logic prev;
        logic fire;
        logic [7:0] e;
        prev = 1'b0;
        forever begin
            @(posedge clk);
            fire = read && !prev && !reset;
            prev = reset ? 1'b0 : read;
            if (fire) begin
                @(negedge clk);
                check("rd.queue_nonempty", int'(exp_rd.size() != 0), 1);
                if (exp_rd.size() != 0) begin
                    e = exp_rd.pop_front();
                    check("rd.dout", int'(dout), int'(e));
                end
            end
        end
    end

    // Vector monitor: compares on each rising edge of int_vec_valid.
    initial begin
        logic vprev;
        logic [7:0] e;
        vprev = 1'b0;
        forever begin
            @(negedge clk);
            if (int_vec_valid && !vprev) begin
                check("vec.queue_nonempty", int'(exp_vec.size() != 0), 1);
                if (exp_vec.size() != 0) begin
                    e = exp_vec.pop_front();
                    check("vec.int_vec", int'(int_vec), int'(e));
                end
            end
            vprev = int_vec_valid;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] v;
        do_reset();
        check_levels("reset");
        check("reset.vld", int'(int_vec_valid), 0);
        check("reset.vec", int'(int_vec), 0);
        check("reset.dout", int'(dout), 0);
        bus_read(1'b0);
        bus_read(1'b1);

        // Single timer dispatch
        bus_write(1'b1, 8'h04, 5'd0);
        ime_op(1'b1, 1'b0);
        check_levels("noreq_yet");
        pulse(5'b00100);
        check_levels("timer_pend");
        dispatch("timer", 5'd0);
        check_levels("timer_done");
        bus_read(1'b0);

        // Three sources pending, dispatched in priority order
        bus_write(1'b1, 8'h1F, 5'd0);
        ime_op(1'b1, 1'b0);
        pulse(5'h1A);
        for (int k = 0; k < 3; k++) begin
            check_levels("multi");
            dispatch("multi", 5'd0);
            ime_op(1'b1, 1'b0);
        end
        bus_read(1'b0);

        // Wake without IME, then clear IF by write
        ime_op(1'b0, 1'b1);
        bus_write(1'b1, 8'h01, 5'd0);
        pulse(5'b00001);
        check_levels("wake_only");
        bus_write(1'b0, 8'h00, 5'd0);
        check_levels("wake_cleared");

        // Request withdrawn before ack -> vector 00
        bus_write(1'b1, 8'h10, 5'd0);
        bus_write(1'b0, 8'h10, 5'd0);
        ime_op(1'b1, 1'b0);
        check_levels("withdraw_pre");
        bus_write(1'b1, 8'h00, 5'd0);
        dispatch("withdraw", 5'd0);
        bus_read(1'b0);
        bus_write(1'b1, 8'h10, 5'd0);
        check_levels("withdraw_ime_off");

        // Re-request during SEL keeps the bit set
        bus_write(1'b0, 8'h00, 5'd0);
        bus_write(1'b1, 8'h04, 5'd0);
        ime_op(1'b1, 1'b0);
        pulse(5'b00100);
        dispatch("resel1", 5'b00100);
        check_levels("resel_mid");
        bus_read(1'b0);
        ime_op(1'b1, 1'b0);
        check_levels("resel_req");
        dispatch("resel2", 5'd0);

        // Write-to-zero and irq in the same cycle: irq wins
        bus_write(1'b1, 8'h01, 5'd0);
        bus_write(1'b0, 8'h00, 5'b00001);
        bus_read(1'b0);
        // DI beats EI
        ime_op(1'b1, 1'b1);
        check_levels("di_beats_ei");

        // Reset while in HOLD
        ime_op(1'b1, 1'b0);
        v = model_dispatch(5'd0);
        exp_vec.push_back(v);
        int_ack = 1'b1;
        tick();
        tick();
        check("rst_hold.vld_pre", int'(int_vec_valid), 1);
        reset   = 1'b1;
        int_ack = 1'b0;
        tick();
        check("rst_hold.vld", int'(int_vec_valid), 0);
        check("rst_hold.vec", int'(int_vec), 0);
        reset = 1'b0;
        m_if  = 5'd0;
        m_ie  = 8'd0;
        m_ime = 1'b0;
        check_levels("rst_hold");

        // Reset before SEL executes
        bus_write(1'b1, 8'h02, 5'd0);
        pulse(5'b00010);
        ime_op(1'b1, 1'b0);
        int_ack = 1'b1;
        tick();
        reset   = 1'b1;
        int_ack = 1'b0;
        tick();
        reset = 1'b0;
        tick();
        m_if  = 5'd0;
        m_ie  = 8'd0;
        m_ime = 1'b0;
        check("rst_sel.vld", int'(int_vec_valid), 0);
        check_levels("rst_sel");
        bus_read(1'b0);

        // Randomized traffic
        for (int n = 0; n < 300; n++) begin
            case ($urandom_range(0, 6))
                0: bus_write(1'b0, 8'($urandom), 5'(($urandom_range(0, 3) == 0) ? $urandom : 0));
                1: bus_write(1'b1, 8'($urandom), 5'd0);
                2: bus_read(1'($urandom));
                3: pulse(5'($urandom));
                4: ime_op(1'($urandom), 1'($urandom_range(0, 3) == 0));
                default: dispatch("rand", 5'(($urandom_range(0, 2) == 0) ? $urandom : 0));
            endcase
            check_levels("rand");
        end

        tick();
        tick();
        check("end.rd_queue_empty", exp_rd.size(), 0);
        check("end.vec_queue_empty", exp_vec.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
